// File: rtl/l2_pkg.sv
// Shared types and defaults for the 4-way L2 cache control slice.
package l2_pkg;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_INDEX  = 4;
  localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned NUM_WAYS = 4;

  typedef logic [1:0] way_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    REFILL_WAIT
  } l2_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic way_idx_t lowest_way(input logic [NUM_WAYS-1:0] vec);
    way_idx_t idx;
    logic     found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (vec[i] && !found) begin
        idx   = way_idx_t'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/l2_victim_sel.sv
// Victim way selection: lowest invalid way first, otherwise the PLRU way.
module l2_victim_sel
  import l2_pkg::*;
(
  input  logic [NUM_WAYS-1:0] way_valid,
  input  way_idx_t            plru_way,
  output way_idx_t            victim
);

  // Prefer filling an empty way before evicting anything.
  always_comb begin
    victim = plru_way;
    if (!(&way_valid)) begin
      victim = lowest_way(~way_valid);
    end
  end

endmodule

// File: rtl/l2_ctrl.sv
// L2 cache control FSM between the UFP request port and the DFP line adapter.
// Optional performance counters are enabled with `define L2_PERF_CNT_EN.
module l2_ctrl
  import l2_pkg::*;
#(
  parameter int unsigned s_offset = S_OFFSET,
  parameter int unsigned s_index  = S_INDEX,
  parameter int unsigned s_tag    = 32 - s_offset - s_index,
  parameter int unsigned num_ways = NUM_WAYS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ufp_req,
  input  logic                ufp_we,
  input  logic [31:0]         ufp_addr,
  output logic                ufp_resp,
  input  logic [num_ways-1:0] way_hit,
  input  logic [num_ways-1:0] way_valid,
  input  logic [num_ways-1:0] way_dirty,
  input  logic [s_tag-1:0]    victim_tag,
  input  logic [1:0]          plru_way,
  output logic                plru_we,
  output logic [1:0]          mru,
  output logic [s_index-1:0]  set_index,
  output logic [1:0]          array_way,
  output logic                tag_we,
  output logic                data_we,
  output logic                fill_sel,
  output logic                dirty_set,
  output logic                dfp_read,
  output logic                dfp_write,
  output logic [31:0]         dfp_addr,
  input  logic                dfp_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  output logic [31:0]         wb_cnt
`endif
);

  l2_state_t               state;
  logic [31-s_offset:0]    line_q;
  logic                    we_q;
  way_idx_t                victim_q;

  logic                    hit;
  way_idx_t                hit_way;
  way_idx_t                victim_way;
  logic                    victim_dirty;
  logic                    unused_offset;

  assign unused_offset = ^ufp_addr[s_offset-1:0];

  assign hit          = |way_hit;
  assign hit_way      = lowest_way(way_hit);
  assign victim_dirty = way_valid[victim_way] & way_dirty[victim_way];

  l2_victim_sel u_victim_sel (
    .way_valid (way_valid),
    .plru_way  (plru_way),
    .victim    (victim_way)
  );

  // State sequencing and request/victim capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      line_q   <= '0;
      we_q     <= 1'b0;
      victim_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ufp_req) begin
            line_q <= ufp_addr[31:s_offset];
            we_q   <= ufp_we;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            victim_q <= victim_way;
            state    <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (dfp_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (dfp_resp) state <= REFILL_WAIT;
        end
        REFILL_WAIT: begin
          state <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control outputs decoded from state; hit responses must land in the
  // compare cycle itself, so they follow way_hit combinationally.
  always_comb begin
    ufp_resp  = 1'b0;
    plru_we   = 1'b0;
    mru       = '0;
    array_way = '0;
    tag_we    = 1'b0;
    data_we   = 1'b0;
    fill_sel  = 1'b0;
    dirty_set = 1'b0;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    dfp_addr  = '0;
    set_index = (state == IDLE) ? ufp_addr[s_offset +: s_index] : line_q[s_index-1:0];
    case (state)
      COMPARE: begin
        if (hit) begin
          ufp_resp  = 1'b1;
          plru_we   = 1'b1;
          mru       = hit_way;
          array_way = hit_way;
          if (we_q) begin
            data_we   = 1'b1;
            dirty_set = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        array_way = victim_q;
        dfp_addr  = {victim_tag, line_q[s_index-1:0], {s_offset{1'b0}}};
      end
      ALLOCATE: begin
        dfp_read  = 1'b1;
        array_way = victim_q;
        dfp_addr  = {line_q, {s_offset{1'b0}}};
        if (dfp_resp) begin
          tag_we   = 1'b1;
          data_we  = 1'b1;
          fill_sel = 1'b1;
        end
      end
      REFILL_WAIT: begin
        array_way = victim_q;
      end
      default: ;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  logic after_refill;

  // Saturating event counters; the compare following a refill is not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      after_refill <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      wb_cnt       <= '0;
    end else begin
      after_refill <= (state == REFILL_WAIT);
      if (state == COMPARE && hit && !after_refill && hit_cnt != '1)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == COMPARE && !hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 32'd1;
      if (state == WRITEBACK && dfp_resp && wb_cnt != '1)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_ctrl.sv
// Self-checking bench for l2_ctrl with a behavioural cache reference model.
module tb_l2_ctrl;

  logic        clk;
  logic        rst;
  logic        ufp_req;
  logic        ufp_we;
  logic [31:0] ufp_addr;
  logic        ufp_resp;
  logic [3:0]  way_hit;
  logic [3:0]  way_valid;
  logic [3:0]  way_dirty;
  logic [22:0] victim_tag;
  logic [1:0]  plru_way;
  logic        plru_we;
  logic [1:0]  mru;
  logic [3:0]  set_index;
  logic [1:0]  array_way;
  logic        tag_we;
  logic        data_we;
  logic        fill_sel;
  logic        dirty_set;
  logic        dfp_read;
  logic        dfp_write;
  logic [31:0] dfp_addr;
  logic        dfp_resp;
`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] wb_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  l2_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ufp_req    (ufp_req),
    .ufp_we     (ufp_we),
    .ufp_addr   (ufp_addr),
    .ufp_resp   (ufp_resp),
    .way_hit    (way_hit),
    .way_valid  (way_valid),
    .way_dirty  (way_dirty),
    .victim_tag (victim_tag),
    .plru_way   (plru_way),
    .plru_we    (plru_we),
    .mru        (mru),
    .set_index  (set_index),
    .array_way  (array_way),
    .tag_we     (tag_we),
    .data_we    (data_we),
    .fill_sel   (fill_sel),
    .dirty_set  (dirty_set),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_addr   (dfp_addr),
    .dfp_resp   (dfp_resp)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment arrays standing in for the external datapath.
  logic [22:0] env_tag [16][4] = '{default: '{default: '0}};
  logic [3:0]  env_v   [16]    = '{default: '0};
  logic [3:0]  env_d   [16]    = '{default: '0};
  logic [3:0]  set_q = '0;

  logic        pre_en = 1'b0;
  logic [3:0]  pre_set;
  logic [1:0]  pre_way;
  logic [22:0] pre_tag;
  logic        pre_v;
  logic        pre_d;

  // Reference model state, updated from the cache rules only.
  logic [22:0] ref_tag [16][4] = '{default: '{default: '0}};
  logic [3:0]  ref_v   [16]    = '{default: '0};
  logic [3:0]  ref_d   [16]    = '{default: '0};

  always @(posedge clk) begin
    set_q <= set_index;
    if (pre_en) begin
      env_tag[pre_set][pre_way] <= pre_tag;
      env_v[pre_set][pre_way]   <= pre_v;
      env_d[pre_set][pre_way]   <= pre_d;
    end else begin
      if (tag_we) begin
        env_tag[set_index][array_way] <= ufp_addr[31:9];
        env_v[set_index][array_way]   <= 1'b1;
        env_d[set_index][array_way]   <= 1'b0;
      end
      if (dirty_set) env_d[set_index][array_way] <= 1'b1;
    end
  end

  always_comb begin
    way_hit = '0;
    for (int w = 0; w < 4; w++)
      way_hit[w] = env_v[set_q][w] && (env_tag[set_q][w] == ufp_addr[31:9]);
  end
  assign way_valid  = env_v[set_q];
  assign way_dirty  = env_d[set_q];
  assign victim_tag = env_tag[set_q][array_way];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk_addr(input logic [22:0] t, input logic [3:0] i, input logic [4:0] o);
    return {t, i, o};
  endfunction

  task automatic preset(input int s, input int w, input logic [22:0] t, input logic v, input logic d);
    pre_set = 4'(s);
    pre_way = 2'(w);
    pre_tag = t;
    pre_v   = v;
    pre_d   = d;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_tag[s][w] = t;
    ref_v[s][w]   = v;
    ref_d[s][w]   = d;
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [1:0] plru,
                         input int wb_lat, input int rd_lat, input logic spur);
    logic [22:0] tag;
    logic [3:0]  idx;
    logic        hit, dirty, found, done;
    logic [1:0]  exp_way;
    logic [31:0] exp_wb, exp_rd, got_wb, got_rd;
    int          exp_lat, lat, cyc, wcnt, rcnt, wcyc, rcyc, plru_n, tagwe_n, set_bad, overlap, order_bad;
    logic        seen_w, seen_r, tw_ok, r_dwe, r_dset, r_fsel;
    logic [1:0]  r_mru, r_way, tw_way;
    txn_id++;
    tag = addr[31:9];
    idx = addr[8:5];
    hit = 1'b0; exp_way = '0; dirty = 1'b0; exp_wb = '0;
    for (int w = 0; w < 4; w++)
      if (!hit && ref_v[idx][w] && ref_tag[idx][w] == tag) begin hit = 1'b1; exp_way = 2'(w); end
    if (!hit) begin
      exp_way = plru; found = 1'b0;
      for (int w = 0; w < 4; w++)
        if (!found && !ref_v[idx][w]) begin exp_way = 2'(w); found = 1'b1; end
      dirty  = ref_v[idx][exp_way] && ref_d[idx][exp_way];
      exp_wb = {ref_tag[idx][exp_way], idx, 5'b0};
    end
    exp_rd  = {tag, idx, 5'b0};
    exp_lat = hit ? 2 : (2 + (dirty ? wb_lat : 0) + rd_lat + 2);
    if (!hit) begin
      ref_tag[idx][exp_way] = tag;
      ref_v[idx][exp_way]   = 1'b1;
      ref_d[idx][exp_way]   = 1'b0;
    end
    if (we) ref_d[idx][exp_way] = 1'b1;

    ufp_addr = addr; ufp_we = we; plru_way = plru; ufp_req = 1'b1;
    cyc = 0; done = 1'b0; wcnt = 0; rcnt = 0; wcyc = 0; rcyc = 0; plru_n = 0; tagwe_n = 0;
    set_bad = 0; overlap = 0; order_bad = 0; seen_w = 0; seen_r = 0; tw_ok = 0; lat = 0;
    got_wb = '0; got_rd = '0; r_dwe = 0; r_dset = 0; r_fsel = 0; r_mru = '0; r_way = '0; tw_way = '0;
    while (!done && cyc < 60) begin
      cyc++;
      if (dfp_write) begin wcnt++; dfp_resp = (wcnt == wb_lat); end
      else if (dfp_read) begin rcnt++; dfp_resp = (rcnt == rd_lat); end
      else dfp_resp = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (dfp_read && dfp_write) overlap++;
      if (dfp_write) begin if (!seen_w) got_wb = dfp_addr; seen_w = 1; if (seen_r) order_bad++; wcyc++; end
      if (dfp_read) begin if (!seen_r) got_rd = dfp_addr; seen_r = 1; rcyc++; end
      if (tag_we) begin tagwe_n++; tw_way = array_way; tw_ok = data_we && fill_sel; end
      if (plru_we) plru_n++;
      if (set_index !== idx) set_bad++;
      if (ufp_resp) begin
        done = 1'b1; lat = cyc; r_mru = mru; r_way = array_way;
        r_dwe = data_we; r_dset = dirty_set; r_fsel = fill_sel;
        ufp_req = 1'b0;
      end
      if (!done) @(negedge clk);
    end
    ufp_req = 1'b0; dfp_resp = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL txn%0d resp_timeout: got no ufp_resp within %0d cycles", txn_id, cyc); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL txn%0d latency: got %0d expected %0d", txn_id, lat, exp_lat); end
    checks++; if (plru_n !== 1) begin errors++; $display("FAIL txn%0d plru_we_count: got %0d expected 1", txn_id, plru_n); end
    checks++; if (r_mru !== exp_way) begin errors++; $display("FAIL txn%0d mru: got %0d expected %0d", txn_id, r_mru, exp_way); end
    checks++; if (r_dwe !== we || r_dset !== we) begin errors++; $display("FAIL txn%0d resp_write_strobes: got data_we=%0b dirty_set=%0b expected %0b", txn_id, r_dwe, r_dset, we); end
    if (we) begin
      checks++; if (r_fsel !== 1'b0 || r_way !== exp_way) begin errors++; $display("FAIL txn%0d write_hit_way: got fill_sel=%0b way=%0d expected 0/%0d", txn_id, r_fsel, r_way, exp_way); end
    end
    checks++; if (wcyc !== (dirty ? wb_lat : 0)) begin errors++; $display("FAIL txn%0d dfp_write_cycles: got %0d expected %0d", txn_id, wcyc, dirty ? wb_lat : 0); end
    if (dirty) begin
      checks++; if (got_wb !== exp_wb) begin errors++; $display("FAIL txn%0d wb_addr: got %08h expected %08h", txn_id, got_wb, exp_wb); end
    end
    checks++; if (rcyc !== (hit ? 0 : rd_lat)) begin errors++; $display("FAIL txn%0d dfp_read_cycles: got %0d expected %0d", txn_id, rcyc, hit ? 0 : rd_lat); end
    if (!hit) begin
      checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL txn%0d rd_addr: got %08h expected %08h", txn_id, got_rd, exp_rd); end
      checks++; if (tw_way !== exp_way || tw_ok !== 1'b1) begin errors++; $display("FAIL txn%0d refill_write: got way=%0d ok=%0b expected way=%0d ok=1", txn_id, tw_way, tw_ok, exp_way); end
    end
    checks++; if (tagwe_n !== (hit ? 0 : 1)) begin errors++; $display("FAIL txn%0d tag_we_count: got %0d expected %0d", txn_id, tagwe_n, hit ? 0 : 1); end
    checks++; if (overlap !== 0 || order_bad !== 0) begin errors++; $display("FAIL txn%0d dfp_order: got overlap=%0d late_write=%0d expected 0/0", txn_id, overlap, order_bad); end
    checks++; if (set_bad !== 0) begin errors++; $display("FAIL txn%0d set_index: got %0d wrong cycles expected 0", txn_id, set_bad); end
    @(negedge clk); #1;
    checks++; if (ufp_resp !== 1'b0) begin errors++; $display("FAIL txn%0d single_resp: got ufp_resp=%0b expected 0", txn_id, ufp_resp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; ufp_req = 1'b0; ufp_we = 1'b0; dfp_resp = 1'b0; plru_way = '0;
    ufp_addr = mk_addr(23'h1, 4'd7, 5'd3);
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({ufp_resp, plru_we, tag_we, data_we, dirty_set, dfp_read, dfp_write} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes: got %07b expected 0000000", {ufp_resp, plru_we, tag_we, data_we, dirty_set, dfp_read, dfp_write}); end
    checks++; if (dfp_addr !== 32'h0 || array_way !== 2'd0) begin
      errors++; $display("FAIL reset_addr_way: got %08h/%0d expected 0/0", dfp_addr, array_way); end
    checks++; if (set_index !== 4'd7) begin errors++; $display("FAIL idle_set_index: got %0d expected 7", set_index); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_hit();
    preset(1, 0, 23'h1, 1, 0);
    preset(1, 1, 23'h2, 1, 0);
    preset(1, 2, 23'h3, 1, 0);
    run_txn(mk_addr(23'h3, 4'd1, 5'd4), 1'b0, 2'd0, 1, 1, 1'b0);
  endtask

  task automatic test_read_miss();
    preset(2, 0, 23'h10, 1, 1);
    preset(2, 1, 23'h11, 1, 1);
    preset(2, 3, 23'h13, 1, 1);
    run_txn(mk_addr(23'h20, 4'd2, 5'd0), 1'b0, 2'd0, 2, 3, 1'b0);
  endtask

  task automatic test_dirty_miss();
    for (int w = 0; w < 4; w++) preset(3, w, (w == 3) ? 23'h12345 : 23'(w + 'h30), 1, w == 3);
    run_txn(mk_addr(23'h40, 4'd3, 5'd8), 1'b0, 2'd3, 3, 2, 1'b0);
  endtask

  task automatic test_write_hit();
    preset(4, 0, 23'h40, 1, 0);
    preset(4, 1, 23'h44, 1, 0);
    run_txn(mk_addr(23'h44, 4'd4, 5'd12), 1'b1, 2'd2, 1, 1, 1'b1);
  endtask

  task automatic test_multi_hit();
    preset(6, 1, 23'h66, 1, 0);
    preset(6, 3, 23'h66, 1, 0);
    run_txn(mk_addr(23'h66, 4'd6, 5'd0), 1'b0, 2'd0, 1, 1, 1'b0);
  endtask

  task automatic test_reset_mid_wb();
    logic seen;
    for (int w = 0; w < 4; w++) preset(5, w, 23'(w + 'h100), 1, w == 0);
    plru_way = 2'd0; ufp_we = 1'b0; dfp_resp = 1'b0;
    ufp_addr = mk_addr(23'h200, 4'd5, 5'd0);
    ufp_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (dfp_write) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_wb_reach: got no dfp_write expected writeback"); end
    rst = 1'b1; ufp_req = 1'b0;
    @(negedge clk); #1;
    checks++; if ({dfp_write, dfp_read, ufp_resp} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_wb: got write/read/resp=%03b expected 000", {dfp_write, dfp_read, ufp_resp}); end
    rst = 1'b0;
    @(negedge clk);
    run_txn(mk_addr(23'h200, 4'd5, 5'd0), 1'b0, 2'd0, 2, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [22:0] t;
    logic [3:0]  s;
    for (int n = 0; n < 40; n++) begin
      t = 23'('h300 + $urandom_range(0, 5));
      s = 4'(8 + $urandom_range(0, 3));
      run_txn(mk_addr(t, s, 5'($urandom_range(0, 31))), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef L2_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    preset(12, 0, 23'h500, 1, 0);
    for (int w = 0; w < 4; w++) preset(13, w, 23'h0, 0, 0);
    for (int w = 0; w < 4; w++) preset(14, w, 23'(w + 'h600), 1, w == 1);
    run_txn(mk_addr(23'h500, 4'd12, 5'd0), 1'b0, 2'd0, 1, 1, 1'b0);
    run_txn(mk_addr(23'h501, 4'd13, 5'd0), 1'b0, 2'd0, 1, 2, 1'b0);
    run_txn(mk_addr(23'h502, 4'd14, 5'd0), 1'b1, 2'd1, 2, 1, 1'b0);
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("FAIL perf_hit_cnt: got %0d expected 1", hit_cnt); end
    checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL perf_miss_cnt: got %0d expected 2", miss_cnt); end
    checks++; if (wb_cnt !== 32'd1) begin errors++; $display("FAIL perf_wb_cnt: got %0d expected 1", wb_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_dirty_miss();
    test_write_hit();
    test_multi_hit();
    test_reset_mid_wb();
    test_random();
`ifdef L2_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
